// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a digital clock: mode/increment button handling,
// set-mode FSM with idle timeout, counter load/strobe outputs and blink phase.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       load_hour,
  output logic       setting_hour,
  output logic       load_min,
  output logic       setting_min,
  output logic       enable_run,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned IDLE_W = 6;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_BAD      = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mode_q;
  logic              inc_q;
  logic              mode_press;
  logic              inc_press;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;
  logic [IDLE_W-1:0] idle_inc;
  logic              blink_nxt;
  logic              set_hour_nxt;
  logic              set_min_nxt;

  assign mode_press = btn_mode & ~mode_q;
  assign inc_press  = btn_inc & ~inc_q;
  assign idle_inc   = idle_cnt + IDLE_W'(1);
  assign enable_run = tick_1hz & (state == ST_RUN);

  // Next state, idle counter, blink phase and increment strobes.
  // A mode press outranks an inc press; any press outranks the timeout tick.
  always_comb begin
    state_nxt    = state;
    idle_nxt     = idle_cnt;
    blink_nxt    = blink;
    set_hour_nxt = 1'b0;
    set_min_nxt  = 1'b0;
    case (state)
      ST_RUN: begin
        idle_nxt  = '0;
        blink_nxt = 1'b0;
        if (mode_press) state_nxt = ST_SET_HOUR;
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (mode_press) begin
          state_nxt = (state == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
        end else if (inc_press) begin
          idle_nxt     = '0;
          set_hour_nxt = (state == ST_SET_HOUR);
          set_min_nxt  = (state == ST_SET_MIN);
          if (tick_1hz) blink_nxt = ~blink;
        end else if (tick_1hz) begin
          if (idle_inc == IDLE_W'(TIMEOUT_S)) begin
            state_nxt = ST_RUN;
          end else begin
            idle_nxt  = idle_inc;
            blink_nxt = ~blink;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (state_nxt != state) begin
      idle_nxt  = '0;
      blink_nxt = 1'b0;
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      mode         <= 2'b00;
      load_hour    <= 1'b0;
      load_min     <= 1'b0;
      setting_hour <= 1'b0;
      setting_min  <= 1'b0;
      blink        <= 1'b0;
      idle_cnt     <= '0;
      mode_q       <= 1'b0;
      inc_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode         <= state_nxt;
      load_hour    <= (state_nxt == ST_SET_HOUR);
      load_min     <= (state_nxt == ST_SET_MIN);
      setting_hour <= set_hour_nxt;
      setting_min  <= set_min_nxt;
      blink        <= blink_nxt;
      idle_cnt     <= idle_nxt;
      mode_q       <= btn_mode;
      inc_q        <= btn_inc;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (TIMEOUT_S = 3).
module tb_clock_set_ctrl;

  localparam int unsigned TIMEOUT_S = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       load_hour;
  logic       setting_hour;
  logic       load_min;
  logic       setting_min;
  logic       enable_run;
  logic [1:0] mode;
  logic       blink;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  always #5 clock = ~clock;

  clock_set_ctrl #(.TIMEOUT_S(TIMEOUT_S)) dut (
    .clock        (clock),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .load_hour    (load_hour),
    .setting_hour (setting_hour),
    .load_min     (load_min),
    .setting_min  (setting_min),
    .enable_run   (enable_run),
    .mode         (mode),
    .blink        (blink)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
  endtask

  initial begin
    reset    = 1'b1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) cyc();
    check("rst_mode",   8'(mode), 8'd0);
    check("rst_ldh",    8'(load_hour), 8'd0);
    check("rst_ldm",    8'(load_min), 8'd0);
    check("rst_sh",     8'(setting_hour), 8'd0);
    check("rst_sm",     8'(setting_min), 8'd0);
    check("rst_blink",  8'(blink), 8'd0);
    reset = 1'b0;
    cyc();

    // RUN -> SET_HOUR
    btn_mode = 1'b1;
    cyc();
    check("sh_mode", 8'(mode), 8'd1);
    check("sh_ldh",  8'(load_hour), 8'd1);
    check("sh_ldm",  8'(load_min), 8'd0);
    btn_mode = 1'b0;
    cyc();
    check("sh_mode_held", 8'(mode), 8'd1);

    // three inc presses -> three single-cycle setting_hour pulses
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1;
      cyc();
      check("inc_pulse", 8'(setting_hour), 8'd1);
      cyc();
      check("inc_held",  8'(setting_hour), 8'd0);
      btn_inc = 1'b0;
      cyc();
      check("inc_mode",  8'(mode), 8'd1);
    end

    // tick in SET_HOUR: no seconds counted, blink toggles
    tick_1hz = 1'b1;
    #1;
    check("en_run_set", 8'(enable_run), 8'd0);
    cyc();
    tick_1hz = 1'b0;
    check("blink_on", 8'(blink), 8'd1);

    // SET_HOUR -> SET_MIN
    btn_mode = 1'b1;
    cyc();
    check("sm_mode",  8'(mode), 8'd2);
    check("sm_ldm",   8'(load_min), 8'd1);
    check("sm_ldh",   8'(load_hour), 8'd0);
    check("sm_blink", 8'(blink), 8'd0);
    btn_mode = 1'b0;
    cyc();

    // inc held 50 cycles -> one setting_min pulse
    btn_inc = 1'b1;
    pulses  = 0;
    repeat (50) begin
      cyc();
      if (setting_min) pulses++;
    end
    check("held_pulses", 8'(pulses), 8'd1);
    btn_inc = 1'b0;
    cyc();
    check("held_mode", 8'(mode), 8'd2);

    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("sm_blink_on", 8'(blink), 8'd1);

    // asynchronous reset mid-SET_MIN
    #2;
    reset    = 1'b1;
    tick_1hz = 1'b1;
    #1;
    check("arst_mode",  8'(mode), 8'd0);
    check("arst_ldm",   8'(load_min), 8'd0);
    check("arst_blink", 8'(blink), 8'd0);
    check("arst_sm",    8'(setting_min), 8'd0);
    check("arst_en",    8'(enable_run), 8'd1);
    tick_1hz = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // RUN: enable_run mirrors tick, inc ignored
    tick_1hz = 1'b1;
    #1;
    check("run_en_hi", 8'(enable_run), 8'd1);
    cyc();
    tick_1hz = 1'b0;
    #1;
    check("run_en_lo", 8'(enable_run), 8'd0);
    btn_inc = 1'b1;
    cyc();
    check("run_inc_sh",   8'(setting_hour), 8'd0);
    check("run_inc_sm",   8'(setting_min), 8'd0);
    check("run_inc_mode", 8'(mode), 8'd0);
    btn_inc = 1'b0;
    cyc();

    // mode and inc together in SET_HOUR
    press_mode();
    check("co_enter", 8'(mode), 8'd1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    check("co_mode", 8'(mode), 8'd2);
    check("co_sh",   8'(setting_hour), 8'd0);
    check("co_sm",   8'(setting_min), 8'd0);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc();
    check("co_sm2", 8'(setting_min), 8'd0);
    press_mode();
    check("co_exit", 8'(mode), 8'd0);

    // idle timeout after TIMEOUT_S ticks
    press_mode();
    for (int i = 1; i <= 3; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      check("to_mode", 8'(mode), (i < 3) ? 8'd1 : 8'd0);
      cyc();
    end
    check("to_ldh",   8'(load_hour), 8'd0);
    check("to_blink", 8'(blink), 8'd0);

    // press coinciding with the timeout tick wins
    press_mode();
    repeat (2) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
    tick_1hz = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("tp_mode",  8'(mode), 8'd1);
    check("tp_sh",    8'(setting_hour), 8'd1);
    check("tp_blink", 8'(blink), 8'd1);
    btn_inc = 1'b0;
    cyc();
    check("tp_stay", 8'(mode), 8'd1);

    // button high at reset release counts as a press
    reset    = 1'b1;
    btn_mode = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    check("rel_mode", 8'(mode), 8'd1);
    check("rel_ldh",  8'(load_hour), 8'd1);
    btn_mode = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
